// File: rtl/prod_acc_pkg.sv
// Shared types and helpers for the product accumulator.
// Optional build macro: PROD_ACC_SAT_EN (saturating accumulate, see prod_acc_adder).
package prod_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  // Widest accumulator the shared add helper supports.
  localparam int ACC_W_MAX  = 32;

  // Unsigned add of two zero-extended operands; result bit ACC_W is the
  // carry-out for any narrower ACC_W whose operands were zero-extended.
  function automatic logic [ACC_W_MAX:0] acc_add(input logic [ACC_W_MAX-1:0] acc,
                                                 input logic [ACC_W_MAX-1:0] prod);
    return {1'b0, acc} + {1'b0, prod};
  endfunction

endpackage

// File: rtl/prod_acc_adder.sv
// ACC_W-bit accumulate step with carry-out.
// PROD_ACC_SAT_EN defined: sum clamps to all-ones on carry (sticks, since
// any later non-zero add carries again). Undefined: modulo wrap.
module prod_acc_adder
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF    // PROD_W <= ACC_W <= ACC_W_MAX
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W-1:0] raw;

  // Only the low ACC_W+1 bits of the wide add are meaningful.
  assign {carry, raw} = (ACC_W+1)'(acc_add(ACC_W_MAX'(acc), ACC_W_MAX'(prod)));

`ifdef PROD_ACC_SAT_EN
  assign sum = carry ? '1 : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/prod_accumulator.sv
// Accumulates the multiplier's product stream into bursts and hands each
// burst sum downstream over valid/ready.
// Optional build macro: PROD_ACC_SAT_EN (saturating sum instead of wrap).
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter  int PROD_W  = PROD_W_DEF,
  parameter  int ACC_W   = ACC_W_DEF,
  parameter  int MAX_LEN = 8,
  localparam int CNT_W   = $clog2(MAX_LEN+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN-1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, sum;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ovf, ovf_nxt, carry;
  logic             accept, close;

  prod_acc_adder #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
    .acc   (acc),
    .prod  (in_prod),
    .sum   (sum),
    .carry (carry)
  );

  // Handshake flags come straight off the state flop so reset drops them
  // without waiting for a clock edge.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign close     = in_last || (count == LAST_CNT);

  // Registered sum is the output; it only moves in ACCUM so HOLD is stable.
  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

  // Next state: clear beats everything, then accept (ACCUM) or handoff (HOLD).
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    if (clear) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        ACCUM: if (accept) begin
          acc_nxt   = sum;
          count_nxt = count + 1'b1;
          ovf_nxt   = ovf | carry;
          if (close) state_nxt = HOLD;
        end
        HOLD: if (out_ready) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench: two accumulators (ACC_W=16 and ACC_W=9) share one
// stimulus stream; a reference model pushes expected burst results, a
// monitor pops and compares on each output handshake.
module tb_prod_accumulator;

  localparam int MAX_LEN = 8;

  typedef struct {
    int unsigned acc16;
    int unsigned acc9;
    bit          ovf16;
    bit          ovf9;
    int unsigned cnt;
  } exp_t;

  logic       clk, rst_n, clear, in_valid, in_last, out_ready;
  logic [7:0] in_prod;
  logic       in_ready_a, out_valid_a, out_ovf_a;
  logic       in_ready_b, out_valid_b, out_ovf_b;
  logic [15:0] out_acc_a;
  logic [8:0]  out_acc_b;
  logic [3:0]  out_count_a, out_count_b;

  int   errs = 0, checks = 0;
  bit   rnd_rdy = 0;
  exp_t sbq[$];
  exp_t e;
  int unsigned bsum = 0, blen = 0;

  prod_accumulator #(.ACC_W(16), .MAX_LEN(MAX_LEN)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_acc(out_acc_a), .out_count(out_count_a), .out_ovf(out_ovf_a));

  prod_accumulator #(.ACC_W(9), .MAX_LEN(MAX_LEN)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_acc(out_acc_b), .out_count(out_count_b), .out_ovf(out_ovf_b));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected result of a burst from its plain integer total.
  function automatic exp_t mk(input int unsigned s, input int unsigned n);
    exp_t r;
    r.acc16 = s % 65536;
    r.ovf16 = (s > 65535);
    r.ovf9  = (s > 511);
`ifdef PROD_ACC_SAT_EN
    r.acc9  = r.ovf9 ? 511 : s;
`else
    r.acc9  = s % 512;
`endif
    r.cnt   = n;
    return r;
  endfunction

  // Reference model: tracks accepted beats, pushes a result when a burst closes.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n || clear) begin
      bsum = 0; blen = 0; sbq.delete();
    end else if (in_valid && in_ready_a) begin
      bsum += in_prod;
      blen++;
      if (in_last || blen == MAX_LEN) begin
        sbq.push_back(mk(bsum, blen));
        bsum = 0; blen = 0;
      end
    end
  end

  // Monitor: a pending expected result means both DUTs must be presenting it.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid_a", out_valid_a, sbq.size() != 0);
      chk("in_ready_a",  in_ready_a,  sbq.size() == 0);
      chk("out_valid_b", out_valid_b, sbq.size() != 0);
      chk("in_ready_b",  in_ready_b,  sbq.size() == 0);
      if (sbq.size() != 0) begin
        e = sbq[0];
        chk("acc16", out_acc_a,   e.acc16);
        chk("cnt16", out_count_a, e.cnt);
        chk("ovf16", out_ovf_a,   e.ovf16);
        chk("acc9",  out_acc_b,   e.acc9);
        chk("cnt9",  out_count_b, e.cnt);
        chk("ovf9",  out_ovf_b,   e.ovf9);
        if (out_ready && !clear) void'(sbq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    in_prod  = 8'($urandom);
    in_last  = 1'($urandom);
    repeat (n) tick();
  endtask

  // Offer one beat and hold it until the block takes it.
  task automatic send(input logic [7:0] p, input logic l);
    bit ok;
    int n = 0;
    in_valid = 1; in_prod = p; in_last = l;
    do begin
      @(negedge clk);
      ok = in_ready_a && !clear;
      tick();
      n++;
    end while (!ok && n < 50);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL send_timeout: beat %0d not accepted in %0d cycles", p, n);
    end
    in_valid = 0;
    in_prod  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  initial begin
    rst_n = 0; clear = 0; in_valid = 0; in_prod = 0; in_last = 0; out_ready = 1;
    #1;
    chk("rst_in_ready",  in_ready_a,  1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_acc",   out_acc_a,   0);
    chk("rst_out_count", out_count_a, 0);
    chk("rst_out_ovf",   out_ovf_a,   0);
    repeat (2) tick();
    rst_n = 1;
    tick();

    // Basic burst: 15 + 16 + 225 = 256.
    send(15, 0); send(16, 0); send(225, 1);
    idle(3);

    // MAX_LEN close at 8 beats, then a 9th beat starts a new burst.
    for (int i = 0; i < 8; i++) send(10, 0);
    send(10, 0); send(10, 1);
    idle(2);

    // Backpressure: result of 42 held for several cycles, next beat stalled.
    out_ready = 0;
    send(40, 0); send(2, 1);
    fork
      send(3, 1);
      begin repeat (6) tick(); out_ready = 1; end
    join
    idle(3);

    // Overflow: 255 + 255 + 10 exceeds 9 bits.
    send(255, 0); send(255, 0); send(10, 1);
    idle(2);

    // Clear beats a coincident beat; the following burst starts from zero.
    send(50, 0);
    clear = 1; in_valid = 1; in_prod = 100; in_last = 0;
    tick();
    clear = 0; in_valid = 0;
    send(7, 1);
    idle(2);

    // Asynchronous reset while holding a result.
    out_ready = 0;
    send(5, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid_a, 0);
    chk("arst_in_ready",  in_ready_a,  1);
    chk("arst_out_acc",   out_acc_a,   0);
    chk("arst_out_count", out_count_a, 0);
    chk("arst_out_ovf",   out_ovf_a,   0);
    chk("arst_out_valid_b", out_valid_b, 0);
    tick();
    rst_n = 1;
    out_ready = 1;
    idle(2);

    // Random bursts with random backpressure and occasional clears.
    rnd_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        clear = 1; tick(); clear = 0;
      end else if (r < 4) begin
        idle(1);
      end else begin
        send(8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
      end
    end
    rnd_rdy = 0;
    out_ready = 1;
    idle(4);
    chk("drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
